// File: rtl/sim_exit_reporter.sv
// Decodes exit writes on the tohost channel and raises sticky io_success/io_failure after a drain delay.
// Optional heartbeat watchdog enabled by defining SIM_EXIT_HEARTBEAT_EN.
module sim_exit_reporter #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 64,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(32'h8000_1000),
  parameter int                DRAIN_CYCLES = 16
`ifdef SIM_EXIT_HEARTBEAT_EN
  ,
  parameter int                HB_TIMEOUT   = 1000000
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_valid,
`ifdef SIM_EXIT_HEARTBEAT_EN
  input  logic              hb_pulse,
`endif
  output logic              io_success,
  output logic              io_failure,
  output logic [DATA_W-2:0] io_exit_code
);

  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-2:0] code_q, code_d;
  logic              ack_q, ack_d;
  logic              req_ready_q, req_ready_d;
  logic              accept;
  logic              is_exit;
`ifdef SIM_EXIT_HEARTBEAT_EN
  logic [31:0]       hb_cnt_q, hb_cnt_d;
  logic              hb_expire;
`endif

  assign accept  = req_valid & req_ready_q;
  assign is_exit = accept && (req_addr == TOHOST_ADDR) && req_data[0];

`ifdef SIM_EXIT_HEARTBEAT_EN
  // Any accepted write counts as progress, so only silent idle cycles advance the watchdog.
  assign hb_expire = (state_q == IDLE) && !hb_pulse && !accept &&
                     (hb_cnt_q == 32'(HB_TIMEOUT - 1));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    ack_d   = accept;
`ifdef SIM_EXIT_HEARTBEAT_EN
    hb_cnt_d = ((state_q == IDLE) && !hb_pulse && !accept) ? hb_cnt_q + 32'd1 : 32'd0;
`endif
    case (state_q)
      IDLE: begin
        if (is_exit) begin
          state_d = DRAIN;
          code_d  = req_data[DATA_W-1:1];
          cnt_d   = DRAIN_LOAD;
`ifdef SIM_EXIT_HEARTBEAT_EN
        end else if (hb_expire) begin
          state_d = FAIL;
          code_d  = '1;
`endif
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = (code_q == '0) ? PASS : FAIL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      ack_q       <= 1'b0;
      req_ready_q <= 1'b1;
`ifdef SIM_EXIT_HEARTBEAT_EN
      hb_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      ack_q       <= ack_d;
      req_ready_q <= req_ready_d;
`ifdef SIM_EXIT_HEARTBEAT_EN
      hb_cnt_q    <= hb_cnt_d;
`endif
    end
  end

  // Outputs are forced low for the whole reset window, including before the first reset edge.
  assign req_ready    = req_ready_q & ~reset;
  assign ack_valid    = ack_q & ~reset;
  assign io_success   = (state_q == PASS) & ~reset;
  assign io_failure   = (state_q == FAIL) & ~reset;
  assign io_exit_code = (io_success | io_failure) ? code_q : '0;

endmodule

// File: tb/tb_sim_exit_reporter.sv
// Scoreboard bench for sim_exit_reporter: directed handshake scenarios followed by randomized trials.
module tb_sim_exit_reporter;

  localparam int DRAIN = 16;
  localparam logic [31:0] TOHOST = 32'h8000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic        ack_valid;
  logic        io_success;
  logic        io_failure;
  logic [62:0] io_exit_code;
`ifdef SIM_EXIT_HEARTBEAT_EN
  logic        hb_pulse = 1'b1;
`endif

  sim_exit_reporter #(
    .ADDR_W(32), .DATA_W(64), .TOHOST_ADDR(TOHOST), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_data(req_data),
    .ack_valid(ack_valid),
`ifdef SIM_EXIT_HEARTBEAT_EN
    .hb_pulse(hb_pulse),
`endif
    .io_success(io_success),
    .io_failure(io_failure),
    .io_exit_code(io_exit_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    logic        pass;
    logic [62:0] code;
  } res_t;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int unsigned ack_exp_q[$];
  res_t        res_exp_q[$];
  res_t        cur_res;
  logic        cur_valid = 1'b0;
  logic        model_busy = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every cycle against the scoreboard expectations.
  always @(negedge clock) begin
    logic exp_ack;
    if (reset) begin
      chk("reset_outputs", {req_ready, ack_valid, io_success, io_failure, io_exit_code}, 64'd0);
    end else begin
      exp_ack = (ack_exp_q.size() > 0) && (ack_exp_q[0] == cyc);
      if (exp_ack) void'(ack_exp_q.pop_front());
      chk("ack_valid", {63'd0, ack_valid}, {63'd0, exp_ack});
      if (ack_exp_q.size() > 0 && ack_exp_q[0] < cyc) begin
        chk("ack_missed", 64'(ack_exp_q[0]), 64'(cyc));
        void'(ack_exp_q.pop_front());
      end
      if (res_exp_q.size() > 0 && res_exp_q[0].cyc == cyc) begin
        cur_res   = res_exp_q.pop_front();
        cur_valid = 1'b1;
      end
      chk("io_success", {63'd0, io_success}, {63'd0, cur_valid && cur_res.pass});
      chk("io_failure", {63'd0, io_failure}, {63'd0, cur_valid && !cur_res.pass});
      chk("io_exit_code", {1'b0, io_exit_code}, {1'b0, cur_valid ? cur_res.code : 63'd0});
      chk("req_ready", {63'd0, req_ready}, {63'd0, !model_busy});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    ack_exp_q.delete();
    res_exp_q.delete();
    cur_valid  = 1'b0;
    model_busy = 1'b0;
    idle(n);
    reset = 1'b0;
    $display("reset cycles=%0d", n);
  endtask

  // One write presented for one cycle; the model decides whether it is accepted.
  task automatic do_write(input logic [31:0] addr, input logic [63:0] data);
    int unsigned k;
    logic        acc;
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    @(posedge clock);
    k   = cyc;
    acc = !model_busy;
    if (acc) begin
      ack_exp_q.push_back(k + 1);
      if (addr == TOHOST && data[0]) begin
        model_busy = 1'b1;
        res_exp_q.push_back('{cyc: k + DRAIN + 2, pass: (data[63:1] == 63'd0), code: data[63:1]});
      end
    end
    #1;
    req_valid = 1'b0;
    $display("write edge=%0d addr=0x%08h data=0x%016h accepted=%0d", k, addr, data, acc);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(2))
      0:       a = TOHOST;
      1:       a = 32'h8000_2000;
      default: a = $urandom();
    endcase
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [62:0] code;
    logic [31:0] a;
    logic [63:0] d;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    do_reset(5);
    idle(2);
    // Pass: code 0.
    do_write(TOHOST, 64'h1);
    idle(DRAIN + 5);
    // Fail: code 3.
    do_reset(2);
    do_write(TOHOST, 64'h7);
    idle(DRAIN + 5);
    // Console traffic and foreign address are acked and ignored.
    do_reset(2);
    do_write(TOHOST, 64'h40);
    do_write(32'h8000_2000, 64'h1);
    idle(DRAIN + 5);
    // Reset in the middle of the drain, then a clean exit.
    do_write(TOHOST, 64'h1);
    idle(8);
    do_reset(1);
    idle(3);
    do_write(TOHOST, 64'h1);
    do_write(TOHOST, 64'h1);
    idle(DRAIN + 5);

    for (int t = 0; t < 40; t++) begin
      do_reset($urandom_range(3, 1));
      idle($urandom_range(2));
      for (int w = $urandom_range(3); w > 0; w--) begin
        a = rand_addr();
        d = {$urandom(), $urandom()};
        if (a == TOHOST) d[0] = 1'b0;
        do_write(a, d);
        idle($urandom_range(2));
      end
      code = ($urandom_range(9) < 4) ? 63'd0 :
             (($urandom_range(1) == 1) ? 63'($urandom_range(255, 1)) : {$urandom(), $urandom()} >> 1);
      do_write(TOHOST, {code, 1'b1});
      if ($urandom_range(3) == 0) begin
        idle($urandom_range(DRAIN));
      end else begin
        for (int w = 0; w < 4; w++) begin
          idle($urandom_range(6));
          do_write(rand_addr(), {$urandom(), $urandom()} | 64'h1);
        end
        idle(DRAIN + 3);
      end
    end
    idle(3);
    chk("ack_queue_drained", 64'(ack_exp_q.size()), 64'd0);
    chk("result_queue_drained", 64'(res_exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
